mmio_bus_ctrl: RTL

//  Memory-mapped bus controller between the cpu memory port and on-chip RAM plus

---
 rtl/mmio_bus_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: registered MMIO decoder for RAM, output registers and synchronised input ports
module mmio_bus_ctrl #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 9,
    parameter int              RAM_AW   = 8,
    parameter int              RAM_LAT  = 1,
    parameter int              NUM_OUT  = 2,
    parameter int              NUM_IN   = 2,
    parameter logic [ADDR_W-1:0] OUT_BASE = 9'h100,
    parameter logic [ADDR_W-1:0] IN_BASE  = 9'h140
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [1:0]                mem_cmd,
    input  logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         write_data,
    output logic [DATA_W-1:0]         read_data,
    output logic                      mem_ready,
    output logic [RAM_AW-1:0]         ram_addr,
    output logic                      ram_write,
    output logic [DATA_W-1:0]         ram_din,
    input  logic [DATA_W-1:0]         ram_dout,
    output logic [NUM_OUT*DATA_W-1:0] out_regs,
    input  logic [NUM_IN*DATA_W-1:0]  in_ports,
    output logic                      bus_err
);
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;
    localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                    state_q, state_d;
    logic [1:0]                cmd_q, cmd_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [NUM_OUT*DATA_W-1:0] out_q, out_d;
    logic [NUM_IN*DATA_W-1:0]  sync1_q, sync2_q;
    logic                      ram_hit, out_hit, in_hit;
    logic [DATA_W-1:0]         out_rd, in_rd;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            out_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            out_q   <= out_d;
            sync1_q <= in_ports;
            sync2_q <= sync1_q;
        end
    end
    // Decode works on the latched address so the response never depends on the live bus
    always_comb begin
        ram_hit = ~addr_q[ADDR_W-1];
        out_hit = 1'b0;
        in_hit  = 1'b0;
        out_rd  = '0;
        in_rd   = '0;
        out_d   = out_q;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (addr_q == OUT_BASE + ADDR_W'(i)) begin
                out_hit = 1'b1;
                out_rd  = out_q[i*DATA_W +: DATA_W];
                if (state_q == RESP && cmd_q == MWRITE)
                    out_d[i*DATA_W +: DATA_W] = wdata_q;
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (addr_q == IN_BASE + ADDR_W'(i)) begin
                in_hit = 1'b1;
                in_rd  = sync2_q[i*DATA_W +: DATA_W];
            end
        end
    end
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        mem_ready = 1'b0;
        ram_write = 1'b0;
        read_data = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_cmd == MREAD || mem_cmd == MWRITE) begin
                    cmd_d   = mem_cmd;
                    addr_d  = mem_addr;
                    wdata_d = write_data;
                    state_d = (mem_cmd == MREAD && !mem_addr[ADDR_W-1]) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_W'(RAM_LAT - 1)) ? RESP : WAIT;
            end
            RESP: begin
                mem_ready = 1'b1;
                state_d   = IDLE;
                ram_write = ram_hit && cmd_q == MWRITE;
                read_data = (cmd_q != MREAD) ? '0 : ram_hit ? ram_dout : out_hit ? out_rd : in_rd;
                err_d     = err_q | ~(ram_hit | out_hit | in_hit);
            end
            default: state_d = IDLE;
        endcase
    end
    assign ram_addr = addr_q[RAM_AW-1:0];
    assign ram_din  = wdata_q;
    assign out_regs = out_q;
    assign bus_err  = err_q;
endmodule
